// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared pipeline types and constants for the fetch/decode path.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    // sll $0,$0,0 encodes as all zeros
    localparam logic [31:0] INSTR_NOP = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fd_entry_t;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/fd_buffer_mem.sv
`default_nettype none
// ============================================================================
// Module      : fd_buffer_mem
// Description : DEPTH-entry register file, one synchronous write port and one
//               asynchronous read port; contents are not reset.
// Revision    : 1.0 - initial release
// ============================================================================
module fd_buffer_mem
    import pipe_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [PTR_W-1:0] wr_addr,
    input  fd_entry_t        wr_data,
    input  logic [PTR_W-1:0] rd_addr,
    output fd_entry_t        rd_data
);

    fd_entry_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule : fd_buffer_mem
`default_nettype wire

// File: rtl/fetch_decode_buffer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_decode_buffer
// Description : Instruction queue between fetch and the decode register; pops
//               only on decode-advance, flushes on redirect, shows NOP when empty.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_decode_buffer
    import pipe_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_instr,
    input  logic [WIDTH-1:0]           in_pc,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_instr,
    output logic [WIDTH-1:0]           out_pc,
    input  logic                       out_ready,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;

    logic      w_push;
    logic      w_pop;
    fd_entry_t w_wr_entry;
    fd_entry_t w_rd_entry;

    // in_ready depends only on registered occupancy, never on out_ready
    assign in_ready  = (count_q != C_DEPTH);
    assign out_valid = (count_q != '0);
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;
    assign count     = count_q;

    assign w_wr_entry.pc    = in_pc;
    assign w_wr_entry.instr = in_instr;

    assign out_instr = out_valid ? w_rd_entry.instr : INSTR_NOP;
    assign out_pc    = out_valid ? w_rd_entry.pc    : '0;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (w_push && !w_pop) begin
                count_d = count_q + 1'b1;
            end else if (w_pop && !w_push) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    fd_buffer_mem #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (w_push & ~flush & ~reset),
        .wr_addr (wr_ptr_q),
        .wr_data (w_wr_entry),
        .rd_addr (rd_ptr_q),
        .rd_data (w_rd_entry)
    );

endmodule : fetch_decode_buffer
`default_nettype wire

// File: tb/tb_fetch_decode_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_decode_buffer
// Description : Directed vector-table bench for fetch_decode_buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_decode_buffer;

    localparam int DEPTH = 4;
    localparam int WIDTH = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_ready;
    logic        flush;
    logic [2:0]  count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fetch_decode_buffer #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_instr  (in_instr),
        .in_pc     (in_pc),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_instr (out_instr),
        .out_pc    (out_pc),
        .out_ready (out_ready),
        .flush     (flush),
        .count     (count)
    );

    // Inputs applied in a cycle; expectations are the outputs seen in that same
    // cycle (i.e. the state left by the previous edge).
    typedef struct {
        logic        rst;
        logic        fl;
        logic        iv;
        logic [31:0] ipc;
        logic [31:0] iins;
        logic        ordy;
        logic [2:0]  ecnt;
        logic        eov;
        logic [31:0] epc;
        logic [31:0] eins;
        logic        eir;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic fl, input logic iv, input logic [31:0] ipc,
                       input logic [31:0] iins, input logic ordy,
                       input logic [2:0] ecnt, input logic eov,
                       input logic [31:0] epc, input logic [31:0] eins,
                       input logic eir);
        vec_t v;
        v.rst = 1'b0; v.fl = fl; v.iv = iv; v.ipc = ipc; v.iins = iins;
        v.ordy = ordy; v.ecnt = ecnt; v.eov = eov; v.epc = epc;
        v.eins = eins; v.eir = eir;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [2:0] ecnt,
                           input logic eov, input logic [31:0] epc,
                           input logic [31:0] eins, input logic eir);
        chk({tag, ".count"},     {29'd0, count},     {29'd0, ecnt});
        chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, eov});
        chk({tag, ".out_pc"},    out_pc,             epc);
        chk({tag, ".out_instr"}, out_instr,          eins);
        chk({tag, ".in_ready"},  {31'd0, in_ready},  {31'd0, eir});
    endtask

    task automatic drive(input logic rst, input logic fl, input logic iv,
                         input logic [31:0] ipc, input logic [31:0] iins,
                         input logic ordy);
        reset = rst; flush = fl; in_valid = iv;
        in_pc = ipc; in_instr = iins; out_ready = ordy;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        tick();

        // reset then idle
        for (int i = 0; i < 5; i++)
            add(0, 0, 32'h0, 32'h0, 0,   3'd0, 0, 32'h0, 32'h0, 1);
        // streaming with decode always advancing
        add(0, 1, 32'h0, 32'hA, 1,        3'd0, 0, 32'h0, 32'h0, 1);
        add(0, 1, 32'h4, 32'hB, 1,        3'd1, 1, 32'h0, 32'hA, 1);
        add(0, 1, 32'h8, 32'hC, 1,        3'd1, 1, 32'h4, 32'hB, 1);
        add(0, 0, 32'h0, 32'h0, 1,        3'd1, 1, 32'h8, 32'hC, 1);
        add(0, 0, 32'h0, 32'h0, 0,        3'd0, 0, 32'h0, 32'h0, 1);
        // fill while stalled, 5th push refused, head held
        add(0, 1, 32'h0,  32'h100, 0,     3'd0, 0, 32'h0, 32'h0,   1);
        add(0, 1, 32'h4,  32'h101, 0,     3'd1, 1, 32'h0, 32'h100, 1);
        add(0, 1, 32'h8,  32'h102, 0,     3'd2, 1, 32'h0, 32'h100, 1);
        add(0, 1, 32'hC,  32'h103, 0,     3'd3, 1, 32'h0, 32'h100, 1);
        add(0, 1, 32'h10, 32'h104, 0,     3'd4, 1, 32'h0, 32'h100, 0);
        for (int i = 0; i < 3; i++)
            add(0, 0, 32'h0, 32'h0, 0,    3'd4, 1, 32'h0, 32'h100, 0);
        // release: drain in order, 0x10 never appears
        add(0, 0, 32'h0, 32'h0, 1,        3'd4, 1, 32'h0, 32'h100, 0);
        add(0, 0, 32'h0, 32'h0, 1,        3'd3, 1, 32'h4, 32'h101, 1);
        add(0, 0, 32'h0, 32'h0, 1,        3'd2, 1, 32'h8, 32'h102, 1);
        add(0, 0, 32'h0, 32'h0, 1,        3'd1, 1, 32'hC, 32'h103, 1);
        add(0, 0, 32'h0, 32'h0, 1,        3'd0, 0, 32'h0, 32'h0,   1);
        // refill, then push+pop while full
        add(0, 1, 32'h40, 32'h200, 0,     3'd0, 0, 32'h0,  32'h0,   1);
        add(0, 1, 32'h44, 32'h201, 0,     3'd1, 1, 32'h40, 32'h200, 1);
        add(0, 1, 32'h48, 32'h202, 0,     3'd2, 1, 32'h40, 32'h200, 1);
        add(0, 1, 32'h4C, 32'h203, 0,     3'd3, 1, 32'h40, 32'h200, 1);
        add(0, 1, 32'h50, 32'h204, 1,     3'd4, 1, 32'h40, 32'h200, 0);
        add(0, 1, 32'h50, 32'h204, 1,     3'd3, 1, 32'h44, 32'h201, 1);
        add(0, 0, 32'h0,  32'h0,   0,     3'd3, 1, 32'h48, 32'h202, 1);
        // flush drops queue and the concurrent push
        add(1, 1, 32'h20, 32'h300, 1,     3'd3, 1, 32'h48, 32'h202, 1);
        add(0, 1, 32'h24, 32'h301, 0,     3'd0, 0, 32'h0,  32'h0,   1);
        add(0, 0, 32'h0,  32'h0,   0,     3'd1, 1, 32'h24, 32'h301, 1);
        add(0, 0, 32'h0,  32'h0,   1,     3'd1, 1, 32'h24, 32'h301, 1);
        add(0, 0, 32'h0,  32'h0,   0,     3'd0, 0, 32'h0,  32'h0,   1);

        foreach (vq[i]) begin
            drive(vq[i].rst, vq[i].fl, vq[i].iv, vq[i].ipc, vq[i].iins, vq[i].ordy);
            #1;
            chk_all($sformatf("vec%0d", i), vq[i].ecnt, vq[i].eov,
                    vq[i].epc, vq[i].eins, vq[i].eir);
            tick();
        end

        // wrap-around: 10 push/pop pairs, pointers start at 1 here
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b0, 1'b1, 32'h1000 + 32'(4 * i), 32'h5000 + 32'(i), i > 0);
            #1;
            if (i > 0) begin
                chk_all($sformatf("wrap%0d", i), 3'd1, 1'b1,
                        32'h1000 + 32'(4 * (i - 1)), 32'h5000 + 32'(i - 1), 1'b1);
            end
            tick();
        end
        drive(1'b0, 1'b0, 1'b1, 32'h1028, 32'h500A, 1'b0);
        #1;
        chk_all("wrap_last", 3'd1, 1'b1, 32'h1024, 32'h5009, 1'b1);
        tick();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        #1;
        chk_all("pre_reset", 3'd2, 1'b1, 32'h1024, 32'h5009, 1'b1);
        tick();

        // mid-op reset ignores the push and pop offered with it
        drive(1'b1, 1'b0, 1'b1, 32'h2000, 32'h6000, 1'b1);
        tick();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        #1;
        chk_all("post_reset", 3'd0, 1'b0, 32'h0, 32'h0, 1'b1);
        tick();
        drive(1'b0, 1'b0, 1'b1, 32'h3000, 32'h7000, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        #1;
        chk_all("after_reset_push", 3'd1, 1'b1, 32'h3000, 32'h7000, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_fetch_decode_buffer
`default_nettype wire
